// File: rtl/div_seq_pkg.sv
// Shared encodings for the multi-cycle divide sequencer used by the EX stage.
// State codes, start/ready levels and sign-mode selects live here.
package div_seq_pkg;

  localparam int DivWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivSigned         = 1'b1;
  localparam logic DivUnsigned       = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, {remainder, quotient} out.
// Signed operands are divided as magnitudes and the signs are fixed up at the end.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DivWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int              CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);
  localparam logic [CntW-1:0] OneCnt  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] OneW   = {{(WIDTH-1){1'b0}}, 1'b1};

  div_state_e           r_state;
  div_state_e           w_state_nxt;
  logic [CntW-1:0]      r_cnt;
  logic [2*WIDTH:0]     r_work;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_signed;
  logic                 r_op1_neg;
  logic                 r_op2_neg;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_signed;
  logic                 w_accept;
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [WIDTH-1:0]     w_op1_abs;
  logic [WIDTH-1:0]     w_op2_abs;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  assign w_signed  = (signed_div_i != DivUnsigned);
  assign w_accept  = (start_i == DivStart) && !annul_i;
  assign w_op1_neg = w_signed & opdata1_i[WIDTH-1];
  assign w_op2_neg = w_signed & opdata2_i[WIDTH-1];
  assign w_op1_abs = w_op1_neg ? (~opdata1_i + OneW) : opdata1_i;
  assign w_op2_abs = w_op2_neg ? (~opdata2_i + OneW) : opdata2_i;

  // Trial subtract is one bit wider so its MSB is the borrow (negative result).
  assign w_trial    = {1'b0, r_work[2*WIDTH-1:WIDTH]} - {1'b0, r_divisor};
  assign w_quot     = r_work[WIDTH-1:0];
  assign w_rem      = r_work[2*WIDTH:WIDTH+1];
  assign w_quot_fix = (r_signed && (r_op1_neg ^ r_op2_neg)) ? (~w_quot + OneW) : w_quot;
  assign w_rem_fix  = (r_signed && r_op1_neg) ? (~w_rem + OneW) : w_rem;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (annul_i) begin
      w_state_nxt = DivFree;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart) begin
            w_state_nxt = (opdata2_i == {WIDTH{1'b0}}) ? DivByZero : DivOn;
          end else begin
            w_state_nxt = DivFree;
          end
        end
        DivByZero: w_state_nxt = DivEnd;
        DivOn: begin
          if (r_cnt == LastCnt) begin
            w_state_nxt = DivEnd;
          end else begin
            w_state_nxt = DivOn;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            w_state_nxt = DivFree;
          end else begin
            w_state_nxt = DivEnd;
          end
        end
        default: w_state_nxt = DivFree;
      endcase
    end
  end

  // Datapath: operand capture, iterations and sign fix-up
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= {CntW{1'b0}};
      r_work    <= {(2*WIDTH+1){1'b0}};
      r_divisor <= {WIDTH{1'b0}};
      r_signed  <= 1'b0;
      r_op1_neg <= 1'b0;
      r_op2_neg <= 1'b0;
      r_result  <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        DivFree: begin
          if (w_accept) begin
            r_signed  <= w_signed;
            r_op1_neg <= w_op1_neg;
            r_op2_neg <= w_op2_neg;
            r_divisor <= w_op2_abs;
            r_work    <= {{WIDTH{1'b0}}, w_op1_abs, 1'b0};
            r_cnt     <= {CntW{1'b0}};
            r_result  <= {(2*WIDTH){1'b0}};
          end
        end
        DivByZero: r_result <= {(2*WIDTH){1'b0}};
        DivOn: begin
          if (r_cnt != LastCnt) begin
            if (w_trial[WIDTH]) begin
              r_work <= {r_work[2*WIDTH-1:0], 1'b0};
            end else begin
              r_work <= {w_trial[WIDTH-1:0], r_work[WIDTH-1:0], 1'b1};
            end
            r_cnt <= r_cnt + OneCnt;
          end else begin
            r_result <= {w_rem_fix, w_quot_fix};
          end
        end
        DivEnd: r_result <= r_result;
        default: r_cnt <= {CntW{1'b0}};
      endcase
    end
  end

  // Output decode from the state register
  always_comb begin
    ready_o  = DivResultNotReady;
    busy_o   = 1'b0;
    result_o = {(2*WIDTH){1'b0}};
    case (r_state)
      DivByZero, DivOn: busy_o = 1'b1;
      DivEnd: begin
        ready_o  = DivResultReady;
        result_o = r_result;
      end
      default: busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq: expected results are queued at start
// and compared by an independent monitor whenever ready_o rises.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] sb_q[$];

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain integer division, truncating toward zero
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a; sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: pop on ready rise, verify result stays steady while ready held
  logic        prev_ready = 1'b0;
  logic [63:0] held_result = 64'd0;
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_ready", {63'd0, ready_o}, 64'd0);
      end else begin
        check("result", result_o, sb_q.pop_front());
      end
    end else if (ready_o && prev_ready) begin
      check("result_stable", result_o, held_result);
    end
    prev_ready  = ready_o;
    held_result = result_o;
  end

  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat, busy_cnt, exp_lat;
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    sb_q.push_back(ref_div(s, a, b));
    exp_lat = (b == 32'd0) ? 2 : 34;
    @(negedge clk);
    lat = 1;
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    busy_cnt = busy_o ? 1 : 0;
    while (!ready_o && lat < 100) begin
      if (lat == 5) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~signed_div_i;
      end
      @(negedge clk);
      lat++;
      if (busy_o) busy_cnt++;
    end
    check("ready_latency", 64'(lat), 64'(exp_lat));
    if (b != 32'd0) check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_low_at_end", {63'd0, busy_o}, 64'd0);
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("cleared_after_drop", {result_o[62:0], ready_o}, 64'd0);
  endtask

  task automatic abort_run(input bit use_reset, input int at_iter, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(negedge clk);
    repeat (at_iter) @(negedge clk);
    if (use_reset) rst = 1'b0; else annul_i = 1'b1;
    @(negedge clk);
    check(use_reset ? "reset_outputs" : "annul_outputs", {result_o, ready_o, busy_o}, 66'd0);
    rst = 1'b1; annul_i = 1'b0; start_i = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) break;
    end
    check("no_late_ready", {62'd0, ready_o, busy_o}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_state", {result_o, ready_o, busy_o}, 66'd0);
    rst = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_op(1'b1, 32'd1234, 32'd0, 0);
    run_op(1'b0, 32'hDEAD_BEEF, 32'd0, 2);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5);

    abort_run(1'b0, 10, 32'd5000, 32'd3);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

    // annul together with start in the free state must not launch
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(negedge clk);
    check("annul_beats_start", {62'd0, busy_o, ready_o}, 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    abort_run(1'b1, 20, 32'h1234_5678, 32'd17);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
      if (i % 5 == 0) b = 32'd0;
      if (i % 3 == 0) a = a >> $urandom_range(0, 31);
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
